// File: rtl/cache_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_access_controller
// Description : Request sequencer for a direct-mapped, write-through,
//               no-write-allocate cache. Accepts one CPU load/store at a
//               time, looks it up in the external tag store, refills on read
//               misses from main memory, forwards every store to memory and
//               keeps saturating hit/miss statistics.
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   reset        : synchronous, active-low reset
//   cpu_req      : request strobe, only sampled while idle
//   cpu_we       : 1 = store, 0 = load
//   cpu_addr     : request address
//   cpu_wdata    : store data
//   cpu_ready    : one-cycle completion pulse
//   cpu_rdata    : load result, valid while cpu_ready is high
//   tag_addr     : latched request address presented to the tag store
//   tag_wr_en    : tag store write enable (refill)
//   tag_hit      : combinational hit flag from the tag store
//   data_index   : data array index (low address bits)
//   data_we      : data array write enable
//   data_wdata   : data array write data
//   data_rdata   : asynchronous data array read at data_index
//   mem_req      : main-memory request, held until mem_ack
//   mem_we       : memory write (1) / read (0)
//   mem_addr     : memory address (latched request address)
//   mem_wdata    : memory write data
//   mem_rdata    : memory read data, valid with mem_ack
//   mem_ack      : one-cycle memory completion
//   hit_count    : saturating count of read and write hits
//   miss_count   : saturating count of read and write misses
//
// Revision    : 1.0  initial release
// ============================================================================
module cache_access_controller #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int CACHE_DEPTH = 8,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   // CPU side
   input  logic                           cpu_req,
   input  logic                           cpu_we,
   input  logic [ADDR_WIDTH-1:0]          cpu_addr,
   input  logic [DATA_WIDTH-1:0]          cpu_wdata,
   output logic                           cpu_ready,
   output logic [DATA_WIDTH-1:0]          cpu_rdata,
   // Tag store
   output logic [ADDR_WIDTH-1:0]          tag_addr,
   output logic                           tag_wr_en,
   input  logic                           tag_hit,
   // Data array
   output logic [$clog2(CACHE_DEPTH)-1:0] data_index,
   output logic                           data_we,
   output logic [DATA_WIDTH-1:0]          data_wdata,
   input  logic [DATA_WIDTH-1:0]          data_rdata,
   // Main memory
   output logic                           mem_req,
   output logic                           mem_we,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic [DATA_WIDTH-1:0]          mem_wdata,
   input  logic [DATA_WIDTH-1:0]          mem_rdata,
   input  logic                           mem_ack,
   // Statistics
   output logic [CNT_WIDTH-1:0]           hit_count,
   output logic [CNT_WIDTH-1:0]           miss_count
);

   localparam int IDX = $clog2(CACHE_DEPTH);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_st_idle      = 3'd0;
   localparam logic [2:0] c_st_lookup    = 3'd1;
   localparam logic [2:0] c_st_mem_read  = 3'd2;
   localparam logic [2:0] c_st_refill    = 3'd3;
   localparam logic [2:0] c_st_mem_write = 3'd4;
   localparam logic [2:0] c_st_resp      = 3'd5;

   localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

   logic [2:0]            r_state;
   logic [2:0]            w_state_next;

   // Request registers: the request is frozen here for the whole transaction
   // so the tag store and memory see stable address/data regardless of the
   // CPU bus.
   logic [ADDR_WIDTH-1:0] r_addr_q;
   logic                  r_we_q;
   logic [DATA_WIDTH-1:0] r_wdata_q;
   logic [DATA_WIDTH-1:0] r_fill_q;
   logic [DATA_WIDTH-1:0] r_cpu_rdata;
   logic [CNT_WIDTH-1:0]  r_hit_count;
   logic [CNT_WIDTH-1:0]  r_miss_count;

   logic                  w_accept;
   logic                  w_lookup_hit;
   logic                  w_lookup_miss;
   logic                  w_fill_done;

   assign w_accept      = (r_state == c_st_idle) && cpu_req;
   assign w_lookup_hit  = (r_state == c_st_lookup) && tag_hit;
   assign w_lookup_miss = (r_state == c_st_lookup) && !tag_hit;
   assign w_fill_done   = (r_state == c_st_mem_read) && mem_ack;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (cpu_req) begin
               w_state_next = c_st_lookup;
            end
         end
         c_st_lookup: begin
            // Stores always go to memory (write-through); loads only on miss.
            if (r_we_q) begin
               w_state_next = c_st_mem_write;
            end else if (tag_hit) begin
               w_state_next = c_st_resp;
            end else begin
               w_state_next = c_st_mem_read;
            end
         end
         c_st_mem_read: begin
            if (mem_ack) begin
               w_state_next = c_st_refill;
            end
         end
         c_st_refill: begin
            w_state_next = c_st_resp;
         end
         c_st_mem_write: begin
            if (mem_ack) begin
               w_state_next = c_st_resp;
            end
         end
         c_st_resp: begin
            w_state_next = c_st_idle;
         end
         default: begin
            w_state_next = c_st_idle;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------------
   always_comb begin
      cpu_ready  = 1'b0;
      tag_wr_en  = 1'b0;
      data_we    = 1'b0;
      data_wdata = r_fill_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      case (r_state)
         c_st_lookup: begin
            // Store hit updates the cached copy in the same cycle the hit is
            // seen; a store miss leaves the cache untouched (no allocate).
            if (r_we_q && tag_hit) begin
               data_we    = 1'b1;
               data_wdata = r_wdata_q;
            end
         end
         c_st_mem_read: begin
            mem_req = 1'b1;
         end
         c_st_refill: begin
            // Held for the whole cycle: the tag store commits on the falling
            // edge, so the next lookup already sees the new tag.
            tag_wr_en  = 1'b1;
            data_we    = 1'b1;
            data_wdata = r_fill_q;
         end
         c_st_mem_write: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         c_st_resp: begin
            cpu_ready = 1'b1;
         end
         default: begin
            cpu_ready = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request, fill and response data registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr_q    <= '0;
         r_we_q      <= 1'b0;
         r_wdata_q   <= '0;
         r_fill_q    <= '0;
         r_cpu_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr_q  <= cpu_addr;
            r_we_q    <= cpu_we;
            r_wdata_q <= cpu_wdata;
         end
         if (w_lookup_hit && !r_we_q) begin
            r_cpu_rdata <= data_rdata;
         end
         // The fetched word feeds both the refill write and the CPU response.
         if (w_fill_done) begin
            r_fill_q    <= mem_rdata;
            r_cpu_rdata <= mem_rdata;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Saturating statistics counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_lookup_hit && (r_hit_count != c_cnt_max)) begin
            r_hit_count <= r_hit_count + c_cnt_one;
         end
         if (w_lookup_miss && (r_miss_count != c_cnt_max)) begin
            r_miss_count <= r_miss_count + c_cnt_one;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output wiring
   // ------------------------------------------------------------------------
   assign tag_addr   = r_addr_q;
   assign mem_addr   = r_addr_q;
   assign data_index = r_addr_q[IDX-1:0];
   assign mem_wdata  = r_wdata_q;
   assign cpu_rdata  = r_cpu_rdata;
   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_access_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_access_controller
// Description : Directed bench for cache_access_controller with a behavioural
//               direct-mapped tag store / data array and a memory responder.
//               A second instance with 2-bit counters exercises saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cache_access_controller;

   logic        clk;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic [31:0] tag_addr;
   logic        tag_wr_en;
   logic        tag_hit;
   logic [2:0]  data_index;
   logic        data_we;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   // Saturation instance
   logic        s_req;
   logic        s_hit;
   logic        s_ready;
   logic [31:0] s_rdata;
   logic [31:0] s_tag_addr;
   logic        s_tag_wr_en;
   logic [2:0]  s_data_index;
   logic        s_data_we;
   logic [31:0] s_data_wdata;
   logic        s_mem_req;
   logic        s_mem_we;
   logic [31:0] s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic [1:0]  s_hit_count;
   logic [1:0]  s_miss_count;

   int checks;
   int failures;

   // Per-access observations
   int          a_lat;
   int          a_nmem;
   int          a_ntag;
   int          a_ndwe;
   int          a_unstable;
   logic        a_memwe;
   logic [31:0] a_maddr;
   logic [31:0] a_mwdata;
   logic [31:0] a_rdata;

   // Behavioural tag store and data array
   logic        tvalid [8];
   logic [28:0] ttag   [8];
   logic [31:0] dmem   [8];

   cache_access_controller #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .CACHE_DEPTH(8), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .tag_addr(tag_addr), .tag_wr_en(tag_wr_en), .tag_hit(tag_hit),
      .data_index(data_index), .data_we(data_we), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   cache_access_controller #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .CACHE_DEPTH(8), .CNT_WIDTH(2)
   ) dut_sat (
      .clk(clk), .reset(reset),
      .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
      .cpu_ready(s_ready), .cpu_rdata(s_rdata),
      .tag_addr(s_tag_addr), .tag_wr_en(s_tag_wr_en), .tag_hit(s_hit),
      .data_index(s_data_index), .data_we(s_data_we), .data_wdata(s_data_wdata),
      .data_rdata(32'h0),
      .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(32'h0), .mem_ack(1'b1),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign tag_hit    = tvalid[tag_addr[2:0]] && (ttag[tag_addr[2:0]] == tag_addr[31:3]);
   assign data_rdata = dmem[data_index];

   // Tag store and data array commit on the falling edge.
   always @(negedge clk) begin
      if (tag_wr_en) begin
         tvalid[tag_addr[2:0]] <= 1'b1;
         ttag[tag_addr[2:0]]   <= tag_addr[31:3];
      end
      if (data_we) begin
         dmem[data_index] <= data_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // One CPU access; memory acks on the (w+1)-th cycle of mem_req with mrd.
   // a_lat is the index of the edge that samples cpu_ready (0 = accept edge).
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int w, input logic [31:0] mrd);
      int  k;
      bit  done;
      a_lat = 0; a_nmem = 0; a_ntag = 0; a_ndwe = 0; a_unstable = 0;
      a_memwe = 1'b0; a_maddr = '0; a_mwdata = '0; a_rdata = '0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      @(posedge clk); #1 cpu_req = 1'b0;
      k = 0; done = 1'b0;
      for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
         @(negedge clk);
         if (tag_wr_en) a_ntag++;
         if (data_we)   a_ndwe++;
         if (mem_req) begin
            if (a_nmem > 0 && (mem_addr != a_maddr || mem_we != a_memwe || mem_wdata != a_mwdata))
               a_unstable++;
            a_nmem++;
            a_maddr = mem_addr; a_memwe = mem_we; a_mwdata = mem_wdata;
            if (k == w) begin
               mem_ack = 1'b1; mem_rdata = mrd;
            end
            k++;
         end
         if (cpu_ready) begin
            a_lat = cyc; a_rdata = cpu_rdata; done = 1'b1;
         end
         @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = '0;
      end
   endtask

   int spurious;

   initial begin
      checks = 0; failures = 0;
      for (int i = 0; i < 8; i++) begin
         tvalid[i] = 1'b0; ttag[i] = '0; dmem[i] = '0;
      end
      reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0; s_req = 1'b0; s_hit = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready",  {31'b0, cpu_ready}, 32'h0);
      check("rst_memreq", {30'b0, mem_req, mem_we}, 32'h0);
      check("rst_strobe", {30'b0, tag_wr_en, data_we}, 32'h0);
      check("rst_rdata",  cpu_rdata, 32'h0);
      check("rst_addr",   tag_addr, 32'h0);
      check("rst_cnt",    {hit_count, miss_count}, 32'h0);
      @(posedge clk); #1 reset = 1'b1;

      // 1: cold load miss, W=2
      do_access(1'b0, 32'h4, 32'h0, 2, 32'hDEADBEEF);
      check("ld1_lat",   a_lat, 32'd6);
      check("ld1_rdata", a_rdata, 32'hDEADBEEF);
      check("ld1_nmem",  a_nmem, 32'd3);
      check("ld1_memwe", {31'b0, a_memwe}, 32'h0);
      check("ld1_maddr", a_maddr, 32'h4);
      check("ld1_stab",  a_unstable, 32'd0);
      check("ld1_ntag",  a_ntag, 32'd1);
      check("ld1_cnt",   {hit_count, miss_count}, {16'd0, 16'd1});

      // 2: repeat load hits
      do_access(1'b0, 32'h4, 32'h0, 0, 32'h0);
      check("ld2_lat",   a_lat, 32'd2);
      check("ld2_rdata", a_rdata, 32'hDEADBEEF);
      check("ld2_nmem",  a_nmem, 32'd0);
      check("ld2_cnt",   {hit_count, miss_count}, {16'd1, 16'd1});

      // 3: store hit, W=1
      do_access(1'b1, 32'h4, 32'h12345678, 1, 32'h0);
      check("st3_lat",   a_lat, 32'd4);
      check("st3_ndwe",  a_ndwe, 32'd1);
      check("st3_ntag",  a_ntag, 32'd0);
      check("st3_nmem",  a_nmem, 32'd2);
      check("st3_memwe", {31'b0, a_memwe}, 32'h1);
      check("st3_maddr", a_maddr, 32'h4);
      check("st3_mwdat", a_mwdata, 32'h12345678);
      check("st3_stab",  a_unstable, 32'd0);
      check("st3_cnt",   {hit_count, miss_count}, {16'd2, 16'd1});

      // 4: load returns stored value
      do_access(1'b0, 32'h4, 32'h0, 0, 32'h0);
      check("ld4_lat",   a_lat, 32'd2);
      check("ld4_rdata", a_rdata, 32'h12345678);
      check("ld4_nmem",  a_nmem, 32'd0);

      // 5: store miss, W=0: no allocate
      do_access(1'b1, 32'hC, 32'hAAAA5555, 0, 32'h0);
      check("st5_lat",   a_lat, 32'd3);
      check("st5_ntag",  a_ntag, 32'd0);
      check("st5_ndwe",  a_ndwe, 32'd0);
      check("st5_nmem",  a_nmem, 32'd1);
      check("st5_maddr", a_maddr, 32'hC);
      check("st5_mwdat", a_mwdata, 32'hAAAA5555);
      check("st5_cnt",   {hit_count, miss_count}, {16'd3, 16'd2});

      // 6: load of 0xC misses (store did not allocate)
      do_access(1'b0, 32'hC, 32'h0, 0, 32'hCAFE0001);
      check("ld6_lat",   a_lat, 32'd4);
      check("ld6_rdata", a_rdata, 32'hCAFE0001);
      check("ld6_cnt",   {hit_count, miss_count}, {16'd3, 16'd3});

      // 7/8: conflicting 0x14 misses then hits
      do_access(1'b0, 32'h14, 32'h0, 1, 32'h14141414);
      check("ld7_lat",   a_lat, 32'd5);
      check("ld7_rdata", a_rdata, 32'h14141414);
      do_access(1'b0, 32'h14, 32'h0, 0, 32'h0);
      check("ld8_lat",   a_lat, 32'd2);
      check("ld8_rdata", a_rdata, 32'h14141414);

      // 9: 0x4 was evicted
      do_access(1'b0, 32'h4, 32'h0, 0, 32'h44440000);
      check("ld9_lat",   a_lat, 32'd4);
      check("ld9_rdata", a_rdata, 32'h44440000);
      check("ld9_cnt",   {hit_count, miss_count}, {16'd4, 16'd5});

      // 10: reset during MEM_READ aborts the load of 0x24
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h24;
      @(posedge clk); #1 cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ab_memreq", {31'b0, mem_req}, 32'h1);
      check("ab_cnt",    {hit_count, miss_count}, {16'd4, 16'd6});
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("ab_memreq2", {31'b0, mem_req}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      check("ab_drop",   {31'b0, mem_req}, 32'h0);
      check("ab_cnt0",   {hit_count, miss_count}, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = '0;
      spurious = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (cpu_ready || mem_req || tag_wr_en || data_we) spurious++;
      end
      check("ab_quiet",  spurious, 32'd0);

      // 11: no refill happened, so 0x4 still hits with its earlier data
      @(posedge clk); #1;
      do_access(1'b0, 32'h4, 32'h0, 0, 32'h0);
      check("ld11_lat",   a_lat, 32'd2);
      check("ld11_rdata", a_rdata, 32'h44440000);
      check("ld11_cnt",   {hit_count, miss_count}, {16'd1, 16'd0});

      // Saturation with 2-bit counters
      s_hit = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_req = 1'b1;
         @(posedge clk); #1 s_req = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         if (i == 2) check("sat_hit3", {30'b0, s_hit_count}, 32'd3);
      end
      check("sat_hit", {30'b0, s_hit_count}, 32'd3);
      s_hit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_req = 1'b1;
         @(posedge clk); #1 s_req = 1'b0;
         repeat (6) @(posedge clk);
         #1;
      end
      check("sat_miss", {30'b0, s_miss_count}, 32'd3);
      check("sat_hit2", {30'b0, s_hit_count}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cache_access_controller.md
# cache_access_controller

Request-sequencing FSM sitting directly upstream of the direct-mapped tag store and data array. It accepts one CPU load/store at a time, drives the tag store address and write enable, and consumes its combinational hit flag. It services read misses by fetching the word from main memory and refilling tag and data. Writes are write-through, no-write-allocate, and it keeps saturating hit/miss counters.

## Interface
- ADDR_WIDTH, 32, byte/word address width shared with the tag store
- DATA_WIDTH, 32, data word width
- CACHE_DEPTH, 8, number of cache words; IDX = $clog2(CACHE_DEPTH)
- CNT_WIDTH, 16, width of each statistics counter

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_WIDTH  request address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  load result, valid while cpu_ready=1
- tag_addr  out  ADDR_WIDTH  address to tag store (latched request address)
- tag_wr_en  out  1  tag store write enable (refill)
- tag_hit  in  1  combinational hit from tag store for tag_addr
- data_index  out  IDX  data array index = tag_addr[IDX-1:0]
- data_we  out  1  data array write enable
- data_wdata  out  DATA_WIDTH  data array write data
- data_rdata  in  DATA_WIDTH  asynchronous data array read at data_index
- mem_req  out  1  main-memory request, held until mem_ack
- mem_we  out  1  memory write (1) / read (0)
- mem_addr  out  ADDR_WIDTH  memory address (latched request address)
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle memory completion
- hit_count  out  CNT_WIDTH  saturating count of read and write hits
- miss_count  out  CNT_WIDTH  saturating count of read and write misses

## Operation
- Request registers: addr_q, we_q, wdata_q loaded when IDLE sees cpu_req=1. tag_addr, mem_addr, and data_index derive from addr_q. mem_wdata derives from wdata_q.
- IDLE: all strobes low. cpu_req=1 latches the request and moves to LOOKUP.
- LOOKUP (one cycle), decided on tag_hit:
  - load hit: capture data_rdata into cpu_rdata, hit_count+1, go to RESP.
  - load miss: miss_count+1, go to MEM_READ.
  - store hit: data_we=1 and data_wdata=wdata_q this cycle, hit_count+1, go to MEM_WRITE.
  - store miss: miss_count+1, go to MEM_WRITE; the tag store is not touched.
- MEM_READ: mem_req=1, mem_we=0. On mem_ack, capture mem_rdata into the fill register and into cpu_rdata, then go to REFILL.
- REFILL (one cycle): tag_wr_en=1, data_we=1, data_wdata=fill register. Strobes are held for the full cycle so the falling-edge tag store commits. Then go to RESP.
- MEM_WRITE: mem_req=1, mem_we=1. On mem_ack go to RESP.
- RESP (one cycle): cpu_ready=1, then go to IDLE.
- mem_req is asserted from the first cycle of MEM_READ/MEM_WRITE and held stable, with stable address and data, until the cycle mem_ack is sampled high. mem_ack outside those states is ignored.
- cpu_req outside IDLE is ignored. The CPU must not change cpu_* between cpu_req and cpu_ready.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (reset=0 at a rising edge): state=IDLE; cpu_ready, tag_wr_en, data_we, mem_req, mem_we = 0; cpu_rdata, addr_q, wdata_q, fill register, hit_count, miss_count = 0.
- Reset mid-operation aborts the transaction: mem_req drops the next cycle, no refill occurs, and no cpu_ready is issued.
- Latency, with cycle 0 being the edge that samples cpu_req:
  - load hit: cpu_ready at cycle 2.
  - load miss, mem_ack W cycles after mem_req rises: cpu_ready at cycle 4+W.
  - store hit or miss: cpu_ready at cycle 3+W.
- Minimum spacing between accepted requests: cpu_req can be accepted on the cycle after cpu_ready (IDLE).
- mem_ack in the first MEM_* cycle (W=0) is legal.
- A second access to a just-refilled word hits. The tag is committed at the falling edge of REFILL, before the next LOOKUP.

## Test plan
- Reset then load 0x0000_0004 with empty cache → miss_count=1; mem_req/mem_we=0 held until mem_ack (mem_rdata=0xDEADBEEF, W=2); tag_wr_en pulse; cpu_ready at cycle 6 with cpu_rdata=0xDEADBEEF.
- Repeat load 0x0000_0004 → no mem_req; cpu_ready at cycle 2 with cpu_rdata=0xDEADBEEF; hit_count=1.
- Store 0x0000_0004 with data 0x1234_5678 (hit) → data_we in LOOKUP; memory write with mem_addr=0x4 and mem_wdata=0x12345678; the following load returns 0x12345678 with no mem_req.
- Store to miss address 0x0000_000C → no tag_wr_en and no data_we; memory write occurs; a subsequent load of 0xC misses.
- Conflict: load 0x0000_0014 after 0x4 (same index 4) → miss and refill; a later load of 0x4 misses again.
- Reset asserted during MEM_READ (before mem_ack) → mem_req=0 next cycle; counters are 0; no cpu_ready; a late mem_ack is ignored. Also drive a saturation check with preloaded counters at 0xFFFF → the count stays 0xFFFF.
